lsu_ctrl: RTL

Load/store unit sitting between the execute stage and the data memory. It turns one EX-stage memory request into a valid/grant memory transaction, with byte-lane strobes and aligned write data for stores. For loads it extracts and sign- or zero-extends the returned lane and presents the finished 32-bit value as the data-memory operand of the writeback select. While a transaction is outstanding it stalls the pipeline.

---
 rtl/lsu_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit: EX memory request -> valid/grant memory transaction, load extract/extend.
// Latency: store done 2 cycles after accept, load result 3 cycles, +1 per gnt/rvalid wait cycle.
// Backpressure: stall is high while a transaction is outstanding; mem_* held stable until mem_gnt.
module lsu_ctrl #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [4:0]    req_rd,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_wstrb,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          ld_valid,
  output logic [4:0]    ld_rd,
  output logic [DW-1:0] ld_data,
  output logic          st_done,
  output logic          misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state, state_nxt;
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;
  logic [4:0]    rd_q;
  logic          bad_req;
  logic          accept, reject, st_fin, ld_fin;
  logic [3:0]    wstrb_d;
  logic [DW-1:0] wdata_d;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [DW-1:0] ld_ext;

  assign stall   = (state != IDLE);
  assign mem_req = (state == REQ);

  // Unlisted funct3 codes (including unsigned stores) are rejected like misaligned accesses.
  always_comb begin
    bad_req = 1'b1;
    case (req_funct3)
      3'b000:  bad_req = 1'b0;
      3'b001:  bad_req = req_addr[0];
      3'b010:  bad_req = req_addr[1] | req_addr[0];
      3'b100:  bad_req = req_we;
      3'b101:  bad_req = req_we | req_addr[0];
      default: bad_req = 1'b1;
    endcase
  end

  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = req_wdata;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          wstrb_d = 4'b0001 << req_addr[1:0];
          wdata_d = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          wstrb_d = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{req_wdata[15:0]}};
        end
        default: wstrb_d = 4'b1111;
      endcase
    end
  end

  always_comb begin
    lane_b = mem_rdata[{off_q, 3'b000} +: 8];
    lane_h = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
      3'b100:  ld_ext = {24'd0, lane_b};
      3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
      3'b101:  ld_ext = {16'd0, lane_h};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    st_fin    = 1'b0;
    ld_fin    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (bad_req) begin
            reject = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          if (mem_we) begin
            st_fin    = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          ld_fin    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= '0;
      funct3_q  <= 3'b000;
      off_q     <= 2'b00;
      rd_q      <= 5'd0;
      ld_valid  <= 1'b0;
      ld_rd     <= 5'd0;
      ld_data   <= '0;
      st_done   <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      misalign <= reject;
      st_done  <= st_fin;
      ld_valid <= ld_fin;
      if (accept) begin
        mem_we    <= req_we;
        mem_addr  <= {req_addr[AW-1:2], 2'b00};
        mem_wstrb <= wstrb_d;
        mem_wdata <= wdata_d;
        funct3_q  <= req_funct3;
        off_q     <= req_addr[1:0];
        rd_q      <= req_rd;
      end
      if (ld_fin) begin
        ld_data <= ld_ext;
        ld_rd   <= rd_q;
      end
    end
  end

endmodule
